// File: rtl/dx_issue_ctrl_pkg.sv
// rtl/dx_issue_ctrl_pkg.sv - shared opcodes, FSM encoding and mult/div decode for the D/X issue controller
package dx_issue_ctrl_pkg;

  localparam logic [4:0] RTYPE_OP = 5'b00000;
  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam int MAX_CYCLES_DEF = 40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } md_state_t;

  // opcode is ir[31:27], aluop is ir[6:2]
  function automatic logic is_md(input logic valid, input logic [4:0] opcode, input logic [4:0] aluop);
    return valid && (opcode == RTYPE_OP) && ((aluop == ALU_MULT) || (aluop == ALU_DIV));
  endfunction

endpackage

// File: rtl/md_issue_fsm.sv
// rtl/md_issue_fsm.sv - mult/div issue FSM with watchdog counter, start pulse, stall and timeout
module md_issue_fsm
  import dx_issue_ctrl_pkg::*;
#(
  parameter int MAX_CYCLES = MAX_CYCLES_DEF,
  parameter int CNT_W      = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic load_md,
  input  logic data_ready,
  output logic start_op,
  output logic stall,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES - 1);

  md_state_t        state;
  logic [CNT_W-1:0] count;
  logic             at_limit;
  logic             done;

  assign at_limit = (count == LIMIT);
  assign done     = data_ready | at_limit;

  // ready is only trusted in WAIT; in ISSUE it may still belong to the previous op
  always_comb begin
    stall   = 1'b0;
    timeout = 1'b0;
    case (state)
      ISSUE: stall = 1'b1;
      WAIT: begin
        stall   = ~done;
        timeout = at_limit & ~data_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      start_op <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (load_md) begin
            state    <= ISSUE;
            start_op <= 1'b1;
          end
        end
        ISSUE: begin
          state    <= WAIT;
          count    <= '0;
          start_op <= 1'b0;
        end
        WAIT: begin
          if (done) begin
            count    <= '0;
            state    <= load_md ? ISSUE : IDLE;
            start_op <= load_md;
          end else if (!at_limit) begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          count    <= '0;
          start_op <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dx_issue_ctrl.sv
// rtl/dx_issue_ctrl.sv - D/X pipeline register with mult/div issue control and result qualification
module dx_issue_ctrl
  import dx_issue_ctrl_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MAX_CYCLES = MAX_CYCLES_DEF,
  parameter int CNT_W      = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_ir,
  input  logic [WIDTH-1:0] d_regA,
  input  logic [WIDTH-1:0] d_regB,
  input  logic [WIDTH-1:0] d_pc,
  input  logic             d_valid,
  input  logic             flush,
  input  logic             x_data_ready,
  output logic [WIDTH-1:0] x_ir,
  output logic [WIDTH-1:0] x_regA,
  output logic [WIDTH-1:0] x_regB,
  output logic [WIDTH-1:0] x_pc,
  output logic             x_valid,
  output logic             x_startOp,
  output logic             stall,
  output logic             xm_valid,
  output logic             x_timeout
);

  logic load_md;

  // a flushed slot becomes a bubble, so it must never start a mult/div
  assign load_md = ~flush & is_md(d_valid, d_ir[31:27], d_ir[6:2]);

  always_ff @(posedge clock) begin
    if (reset) begin
      x_ir    <= '0;
      x_regA  <= '0;
      x_regB  <= '0;
      x_pc    <= '0;
      x_valid <= 1'b0;
    end else if (!stall) begin
      if (flush) begin
        x_ir    <= '0;
        x_regA  <= '0;
        x_regB  <= '0;
        x_pc    <= '0;
        x_valid <= 1'b0;
      end else begin
        x_ir    <= d_ir;
        x_regA  <= d_regA;
        x_regB  <= d_regB;
        x_pc    <= d_pc;
        x_valid <= d_valid;
      end
    end
  end

  assign xm_valid = x_valid & ~stall;

  md_issue_fsm #(
    .MAX_CYCLES (MAX_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_issue_fsm (
    .clock      (clock),
    .reset      (reset),
    .load_md    (load_md),
    .data_ready (x_data_ready),
    .start_op   (x_startOp),
    .stall      (stall),
    .timeout    (x_timeout)
  );

endmodule

// File: tb/tb_dx_issue_ctrl.sv
// tb/tb_dx_issue_ctrl.sv - directed self-checking bench for dx_issue_ctrl
module tb_dx_issue_ctrl;

  localparam logic [31:0] IR_ADD  = 32'h0000_0000;
  localparam logic [31:0] IR_MULT = 32'h0000_0018;
  localparam logic [31:0] IR_DIV  = 32'h0000_001C;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] d_ir, d_regA, d_regB, d_pc;
  logic        d_valid, flush, x_data_ready;
  logic [31:0] x_ir, x_regA, x_regB, x_pc;
  logic        x_valid, x_startOp, stall, xm_valid, x_timeout;

  int n_cmp = 0;
  int n_err = 0;
  int n_stall, n_start, n_xm, n_to;

  dx_issue_ctrl dut (
    .clock(clock), .reset(reset),
    .d_ir(d_ir), .d_regA(d_regA), .d_regB(d_regB), .d_pc(d_pc),
    .d_valid(d_valid), .flush(flush), .x_data_ready(x_data_ready),
    .x_ir(x_ir), .x_regA(x_regA), .x_regB(x_regB), .x_pc(x_pc),
    .x_valid(x_valid), .x_startOp(x_startOp), .stall(stall),
    .xm_valid(xm_valid), .x_timeout(x_timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic tally();
    if (stall)     n_stall++;
    if (x_startOp) n_start++;
    if (xm_valid)  n_xm++;
    if (x_timeout) n_to++;
  endtask

  // entered in the ISSUE cycle; returns in the done cycle (stall low)
  task automatic run_md(input int ready_k, input logic rdy_issue, input logic [31:0] exp_ir);
    n_stall = 0; n_start = 0; n_xm = 0; n_to = 0;
    x_data_ready = rdy_issue;
    settle();
    tally();
    for (int k = 0; k < 64; k++) begin
      if (!stall) break;
      tick();
      x_data_ready = (k == ready_k);
      settle();
      tally();
    end
    check("md_ir_held", x_ir, exp_ir);
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic v);
    d_ir = ir; d_regA = a; d_regB = b; d_pc = pc; d_valid = v;
  endtask

  // flush is only legal while the pipe is moving
  always @(negedge clock) begin
    if (!reset && flush) check("flush_while_stall", stall, 1'b0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; x_data_ready = 1'b0;
    drive(IR_MULT, 32'h11, 32'h22, 32'h33, 1'b1);
    repeat (3) tick();
    settle();
    check("rst_x_ir", x_ir, 0);
    check("rst_x_pc", x_pc, 0);
    check("rst_x_valid", x_valid, 0);
    check("rst_start", x_startOp, 0);
    check("rst_stall", stall, 0);
    check("rst_xm_valid", xm_valid, 0);
    check("rst_timeout", x_timeout, 0);

    reset = 1'b0;
    drive(IR_ADD, 0, 0, 0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick(); settle();
      check("post_rst_start", x_startOp, 0);
      check("post_rst_stall", stall, 0);
      check("post_rst_valid", x_valid, 0);
    end

    // add: zero-cycle stall
    drive(IR_ADD, 32'd5, 32'd7, 32'h10, 1'b1);
    settle();
    check("add_pre_stall", stall, 0);
    tick();
    d_valid = 1'b0;
    settle();
    check("add_x_ir", x_ir, IR_ADD);
    check("add_x_regA", x_regA, 32'd5);
    check("add_x_regB", x_regB, 32'd7);
    check("add_x_pc", x_pc, 32'h10);
    check("add_x_valid", x_valid, 1);
    check("add_xm_valid", xm_valid, 1);
    check("add_stall", stall, 0);
    check("add_start", x_startOp, 0);
    tick(); settle();
    check("add_bubble_xm", xm_valid, 0);

    // mult: stale ready in ISSUE, real ready in WAIT index 16
    drive(IR_MULT, 32'd3, 32'd4, 32'h20, 1'b1);
    tick();
    drive(IR_ADD, 32'd8, 32'd9, 32'h24, 1'b1);
    run_md(16, 1'b1, IR_MULT);
    check("mult_stall_cycles", n_stall, 17);
    check("mult_start_cycles", n_start, 1);
    check("mult_xm_cycles", n_xm, 1);
    check("mult_timeout", n_to, 0);
    check("mult_regA_held", x_regA, 32'd3);
    tick();
    x_data_ready = 1'b0; d_valid = 1'b0;
    settle();
    check("mult_next_pc", x_pc, 32'h24);
    check("mult_next_xm", xm_valid, 1);
    check("mult_next_stall", stall, 0);

    // mult then div back-to-back
    drive(IR_MULT, 32'd1, 32'd2, 32'h40, 1'b1);
    tick();
    drive(IR_DIV, 32'd6, 32'd3, 32'h44, 1'b1);
    run_md(4, 1'b0, IR_MULT);
    check("b2b1_stall_cycles", n_stall, 5);
    check("b2b1_xm_cycles", n_xm, 1);
    tick();
    x_data_ready = 1'b0;
    drive(IR_ADD, 32'd0, 32'd0, 32'h48, 1'b1);
    settle();
    check("b2b_second_start", x_startOp, 1);
    check("b2b_div_pc", x_pc, 32'h44);
    run_md(4, 1'b0, IR_DIV);
    check("b2b2_stall_cycles", n_stall, 5);
    check("b2b2_start_cycles", n_start, 1);
    check("b2b2_xm_cycles", n_xm, 1);
    tick();
    x_data_ready = 1'b0; d_valid = 1'b0;
    settle();
    check("b2b_add_pc", x_pc, 32'h48);
    check("b2b_add_xm", xm_valid, 1);

    // div with ready stuck low: watchdog
    drive(IR_DIV, 32'd10, 32'd0, 32'h60, 1'b1);
    tick();
    d_valid = 1'b0;
    run_md(-1, 1'b0, IR_DIV);
    check("to_stall_cycles", n_stall, 40);
    check("to_timeout_cycles", n_to, 1);
    check("to_xm_cycles", n_xm, 1);
    tick(); settle();
    check("to_after_timeout", x_timeout, 0);
    check("to_after_stall", stall, 0);
    drive(IR_MULT, 32'd2, 32'd2, 32'h64, 1'b1);
    tick();
    d_valid = 1'b0;
    run_md(2, 1'b0, IR_MULT);
    check("clean_cnt_stall", n_stall, 3);
    check("clean_cnt_timeout", n_to, 0);
    tick(); x_data_ready = 1'b0;

    // flush squashes a mult in the loading slot
    drive(IR_MULT, 32'd9, 32'd9, 32'h80, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0; d_valid = 1'b0;
    settle();
    check("flush_x_valid", x_valid, 0);
    check("flush_x_ir", x_ir, 0);
    check("flush_x_regA", x_regA, 0);
    check("flush_stall", stall, 0);
    tick(); settle();
    check("flush_no_start", x_startOp, 0);

    // reset during WAIT
    drive(IR_MULT, 32'd1, 32'd1, 32'h90, 1'b1);
    tick();
    d_valid = 1'b0;
    tick(); tick(); settle();
    check("rw_in_wait_stall", stall, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("rw_stall", stall, 0);
    check("rw_start", x_startOp, 0);
    check("rw_x_valid", x_valid, 0);
    n_start = 0; n_stall = 0;
    for (int i = 0; i < 5; i++) begin
      tick(); settle();
      if (x_startOp) n_start++;
      if (stall) n_stall++;
    end
    check("rw_no_repulse", n_start, 0);
    check("rw_no_stall", n_stall, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
